add_seq2b: RTL and testbench
============================

Name: add_seq2b

Overview:
Multi-cycle WIDTH-bit adder controller that time-shares a single add2b (2-bit ripple slice built from two fac cells). It latches operands on a start handshake and steps through them 2 bits per clock, least significant first, with a registered carry between slices. It reports the result with a one-cycle done pulse. Used where a full-width adder costs too much area and latency of WIDTH/2+2 cycles per operation is acceptable.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2; slice count N = WIDTH/2

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
x  input  WIDTH  operand A, sampled with start
y  input  WIDTH  operand B, sampled with start
ci  input  1  carry-in, sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, high while in DONE
z  output  WIDTH  sum, registered, holds last result
co  output  1  carry-out of MSB, registered, holds last result

Behaviour:
- Interface fixed: one clock clk; rst synchronous, active-high; only rst and clk affect state outside the handshake.
- Reset (rst=1 at an edge, any state including mid-RUN):
  - state=IDLE; slice counter=0; carry reg=0; operand/accumulator shift regs=0.
  - busy=0, done=0, z=0, co=0.
  - An aborted operation never produces done.
- States IDLE, RUN, DONE; busy and done are decoded from registered state (no input-to-output comb path).
- IDLE:
  - start=1 at edge: latch x, y into shift regs, carry reg<=ci, cnt<=0, go RUN.
  - start=0: stay.
- RUN: one add2b instance with inputs X[1:0], Y[1:0], carry reg. Each edge:
  - accumulator shifts right by 2 with slice sum entering at [WIDTH-1:WIDTH-2];
  - X, Y shift right by 2; carry reg<=slice co; cnt<=cnt+1.
  - On the edge where cnt==N-1: load z<=final accumulator, co<=slice co, go DONE.
- DONE: lasts exactly one cycle, then IDLE unconditionally. start in DONE is ignored.
- start while RUN or DONE is ignored; the latched operands are unaffected.
- Latency: start sampled at edge 0 -> z/co valid and done=1 after edge N, for one cycle. busy=1 after edges 1..N-1 and after edge 0. Throughput with start held high: one op per N+2 cycles.
- z/co keep the previous result during RUN; they change only on entry to DONE or on reset.
- Arithmetic: {co,z} = x + y + ci, mod 2^(WIDTH+1), no saturation. Wrap-around is expressed only via co.
- WIDTH=2: N=1, RUN lasts one cycle. The counter must be at least 1 bit wide.

Optional Feature:
ADDSEQ_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - sub=1: latch ~y and force carry reg<=1 (ci ignored). Result z = x - y mod 2^WIDTH; co=1 means no borrow (x>=y unsigned).
  - sub=0: identical to addition.
- Undefined: port sub absent; addition only; behaviour exactly as above.

Test Plan:
- Reset: rst=1 for 2 cycles from power-up -> busy=0, done=0, z=8'h00, co=0. Assert rst mid-RUN after 2 slices -> next cycle busy=0, z=0, co=0, no done pulse.
- WIDTH=8, x=8'h5A, y=8'h33, ci=0, start 1 cycle -> done exactly 4 edges after the start edge, z=8'h8D, co=0, busy low after done.
- Carry chain: x=8'hFF, y=8'h01, ci=0 -> z=8'h00, co=1. Then x=8'hFF, y=8'hFF, ci=1 -> z=8'hFF, co=1. Then x=0, y=0, ci=1 -> z=8'h01, co=0.
- Ignore-while-busy: start x=8'h10, y=8'h20, then pulse start with x=8'hAA, y=8'h55 during RUN and DONE -> only z=8'h30 reported. start held high continuously -> done pulses every 6 cycles, z stable between them.
- Exhaustive at WIDTH=2: all 32 {x,y,ci} combinations -> {co,z}==x+y+ci for each, one done per op.
- ADDSEQ_SUB_EN: x=8'h10, y=8'h03, sub=1 -> z=8'h0D, co=1. x=8'h03, y=8'h10, sub=1 -> z=8'hF3, co=0. sub=1 with ci=0 still yields the same results.

Source files
------------

// File: rtl/add_seq2b.sv
// add_seq2b: multi-cycle WIDTH-bit adder that reuses one 2-bit ripple slice
// (add2b, built from two fac cells), processing operands LSB-first, two bits
// per clock, with the inter-slice carry held in a register.
//
// Optional feature macro: ADDSEQ_SUB_EN
//   defined   -> extra input port 'sub'; sub=1 computes x - y (two's complement)
//   undefined -> addition only, no 'sub' port
//
// WIDTH must be even and >= 2.

// Single-bit full adder cell.
module fac (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// Two-bit ripple-carry slice made of two full adder cells.
module add2b (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);

  logic c_mid;

  fac u_fac0 (.a(a[0]), .b(b[0]), .ci(ci),    .s(s[0]), .co(c_mid));
  fac u_fac1 (.a(a[1]), .b(b[1]), .ci(c_mid), .s(s[1]), .co(co));

endmodule

module add_seq2b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
`ifdef ADDSEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             co
);

  localparam int N  = WIDTH / 2;
  // Counter needs at least one bit even when a single slice covers the word.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] x_q, y_q, acc_q;

  logic [1:0]       slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] acc_next;
  logic             last_slice;
  logic             sub_sel;
  logic [WIDTH-1:0] y_load;
  logic             carry_load;

`ifdef ADDSEQ_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Subtraction is x + ~y + 1, so invert y and force the initial carry.
  assign y_load     = sub_sel ? ~y : y;
  assign carry_load = sub_sel ? 1'b1 : ci;

  add2b u_slice (
    .a  (x_q[1:0]),
    .b  (y_q[1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // New slice sum enters at the top; after N shifts the word is LSB-aligned.
  // Shift form keeps this legal for WIDTH=2, where no lower bits remain.
  assign acc_next   = (acc_q >> 2) | (WIDTH'(slice_s) << (WIDTH - 2));
  assign last_slice = (cnt_q == CW'(N - 1));

  // Status outputs are pure decodes of the state register.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: operand capture, slice stepping and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      z       <= '0;
      co      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= x;
            y_q     <= y_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          acc_q   <= acc_next;
          x_q     <= x_q >> 2;
          y_q     <= y_q >> 2;
          carry_q <= slice_co;
          cnt_q   <= cnt_q + CW'(1);
          if (last_slice) begin
            z  <= acc_next;
            co <= slice_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq2b.sv
// Directed self-checking bench for add_seq2b: an 8-bit instance for the
// handshake, latency, carry and abort cases, plus a 2-bit instance swept over
// every operand combination. Build with ADDSEQ_SUB_EN to add subtraction cases.
module tb_add_seq2b;

  logic       clk = 1'b0;
  logic       rst;

  logic       start;
  logic [7:0] x, y;
  logic       ci;
  logic       sub;
  logic       busy, done, co;
  logic [7:0] z;

  logic       start2;
  logic [1:0] x2, y2;
  logic       ci2;
  logic       busy2, done2, co2;
  logic [1:0] z2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  add_seq2b #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .ci    (ci),
`ifdef ADDSEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .z     (z),
    .co    (co)
  );

  add_seq2b #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .x     (x2),
    .y     (y2),
    .ci    (ci2),
`ifdef ADDSEQ_SUB_EN
    .sub   (1'b0),
`endif
    .busy  (busy2),
    .done  (done2),
    .z     (z2),
    .co    (co2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation: checks busy, done latency (4 edges), result, and
  // that done drops with busy low on the following cycle.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic s, input logic [7:0] ez, input logic eco);
    int n;
    x = a; y = b; ci = c; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 4);
    check({tag, "_z"}, z, ez);
    check({tag, "_co"}, co, eco);
    tick();
    check({tag, "_done_drop"}, done, 1'b0);
    check({tag, "_busy_drop"}, busy, 1'b0);
  endtask

  initial begin
    int n, pulses, gap, last_pulse, cyc, nd;
    logic [2:0] exp3;

    rst = 1'b1; start = 1'b0; x = '0; y = '0; ci = 1'b0; sub = 1'b0;
    start2 = 1'b0; x2 = '0; y2 = '0; ci2 = 1'b0;

    // Power-up reset, two cycles.
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_z",    z,    8'h00);
    check("rst_co",   co,   1'b0);
    rst = 1'b0;
    tick();

    // Basic addition.
    do_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);

    // Reset mid-RUN after two slices: outputs clear, no done pulse.
    x = 8'hFF; y = 8'hFF; ci = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_z",    z,    8'h00);
    check("abort_co",   co,   1'b0);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);

    // Carry chain.
    do_op("ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    do_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    do_op("00_00_c", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);

    // start and new operands during RUN and DONE are ignored.
    x = 8'h10; y = 8'h20; ci = 1'b0; start = 1'b1;
    tick();                                   // edge 0: accepted
    x = 8'hAA; y = 8'h55;                     // start stays high through RUN/DONE
    tick(); tick(); tick();                   // edges 1..3
    check("ign_busy_mid", busy, 1'b1);
    tick();                                   // edge 4: enter DONE
    check("ign_done", done, 1'b1);
    check("ign_z",    z,    8'h30);
    check("ign_co",   co,   1'b0);
    tick();                                   // edge 5: start seen in DONE, ignored
    start = 1'b0;
    check("ign_done_drop", done, 1'b0);
    check("ign_idle", busy, 1'b0);
    tick();                                   // edge 6: IDLE with start low
    check("ign_stay_idle", busy, 1'b0);
    check("ign_z_hold", z, 8'h30);

    // start held high: done every 6 cycles, z stable in between.
    x = 8'h01; y = 8'h02; ci = 1'b0; start = 1'b1;
    pulses = 0; last_pulse = 0; cyc = 0;
    while (pulses < 3 && cyc < 40) begin
      tick();
      cyc++;
      if (done) begin
        if (pulses > 0) begin
          gap = cyc - last_pulse;
          check("held_gap", gap, 6);
        end
        check("held_z", z, 8'h03);
        last_pulse = cyc;
        pulses++;
      end else if (pulses > 0) begin
        check("held_z_stable", z, 8'h03);
      end
    end
    check("held_pulses", pulses, 3);
    start = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();

`ifdef ADDSEQ_SUB_EN
    do_op("sub_10_03",    8'h10, 8'h03, 1'b1, 1'b1, 8'h0D, 1'b1);
    do_op("sub_03_10",    8'h03, 8'h10, 1'b1, 1'b1, 8'hF3, 1'b0);
    do_op("sub_10_03_c0", 8'h10, 8'h03, 1'b0, 1'b1, 8'h0D, 1'b1);
    do_op("sub_03_10_c0", 8'h03, 8'h10, 1'b0, 1'b1, 8'hF3, 1'b0);
    do_op("sub0_add",     8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
`endif

    // Exhaustive sweep of the 2-bit instance.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          x2 = 2'(a); y2 = 2'(b); ci2 = 1'(c); start2 = 1'b1;
          exp3 = 3'(a + b + c);
          tick();
          start2 = 1'b0;
          n = 0;
          while (!done2 && n < 10) begin
            tick();
            n++;
          end
          check("w2_lat", n, 1);
          check("w2_sum", {co2, z2}, exp3);
          tick();
          check("w2_done_drop", done2, 1'b0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
